// File: rtl/eth_hdr_lookup_ctrl.sv
// Ethernet header lookup controller: parks the first beat of each packet while the
// MAC CAM resolves its destination ports, rewrites tuser[31:24], then streams the rest.
module eth_hdr_lookup_ctrl #(
  parameter int C_AXIS_DATA_WIDTH  = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128,
  parameter int NUM_OUTPUT_QUEUES  = 8
) (
  input  logic                            axi_aclk,
  input  logic                            axi_resetn,

  input  logic [C_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic [C_AXIS_DATA_WIDTH/8-1:0]  s_axis_tkeep,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,

  output logic [C_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [C_AXIS_DATA_WIDTH/8-1:0]  m_axis_tkeep,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready,

  output logic [47:0]                     dst_mac,
  output logic [47:0]                     src_mac,
  output logic [NUM_OUTPUT_QUEUES-1:0]    src_port,
  output logic                            lookup_req,
  input  logic [NUM_OUTPUT_QUEUES-1:0]    dst_ports,
  input  logic                            lookup_done,
  input  logic                            lut_hit,
  input  logic                            lut_miss,

  output logic [31:0]                     pkt_cnt,
  output logic [31:0]                     hit_cnt,
  output logic [31:0]                     miss_cnt
);

  localparam int KEEP_W = C_AXIS_DATA_WIDTH / 8;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_HEAD = 3'd3;
  localparam logic [2:0] ST_BODY = 3'd4;

  logic [2:0]                     state_reg;
  logic [2:0]                     state_next;

  logic [C_AXIS_DATA_WIDTH-1:0]   head_tdata_reg;
  logic [KEEP_W-1:0]              head_tkeep_reg;
  logic [C_AXIS_TUSER_WIDTH-1:0]  head_tuser_reg;
  logic                           head_tlast_reg;

  logic [47:0]                    dst_mac_reg;
  logic [47:0]                    src_mac_reg;
  logic [NUM_OUTPUT_QUEUES-1:0]   src_port_reg;

  logic [31:0]                    pkt_cnt_reg;
  logic [31:0]                    hit_cnt_reg;
  logic [31:0]                    miss_cnt_reg;

  logic [7:0]                     port_field;
  logic [NUM_OUTPUT_QUEUES-1:0]   src_port_field;

  logic                           in_fire;
  logic                           head_fire;
  logic                           wait_done;

  // The tuser port field is 8 bits wide; bitmaps narrower than that are zero-extended.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_port_field
      if (gi < NUM_OUTPUT_QUEUES) begin : g_used
        assign port_field[gi] = dst_ports[gi];
      end else begin : g_pad
        assign port_field[gi] = 1'b0;
      end
    end
    for (gi = 0; gi < NUM_OUTPUT_QUEUES; gi++) begin : g_src_port
      if (gi < 8) begin : g_used
        assign src_port_field[gi] = s_axis_tuser[16+gi];
      end else begin : g_pad
        assign src_port_field[gi] = 1'b0;
      end
    end
  endgenerate

  assign in_fire   = (state_reg == ST_IDLE) && s_axis_tvalid && axi_resetn;
  assign head_fire = (state_reg == ST_HEAD) && m_axis_tready;
  assign wait_done = (state_reg == ST_WAIT) && lookup_done;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (in_fire) state_next = ST_REQ;
      ST_REQ:  state_next = ST_WAIT;
      ST_WAIT: if (lookup_done) state_next = ST_HEAD;
      ST_HEAD: if (m_axis_tready) state_next = head_tlast_reg ? ST_IDLE : ST_BODY;
      ST_BODY: if (s_axis_tvalid && m_axis_tready && s_axis_tlast) state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Reset forces IDLE, so every output decoded from state goes quiet without a clock.
  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tdata  = head_tdata_reg;
    m_axis_tkeep  = head_tkeep_reg;
    m_axis_tuser  = head_tuser_reg;
    m_axis_tlast  = head_tlast_reg;
    m_axis_tvalid = 1'b0;
    lookup_req    = 1'b0;
    case (state_reg)
      ST_IDLE: s_axis_tready = axi_resetn;
      ST_REQ:  lookup_req    = 1'b1;
      ST_HEAD: m_axis_tvalid = 1'b1;
      ST_BODY: begin
        m_axis_tdata  = s_axis_tdata;
        m_axis_tkeep  = s_axis_tkeep;
        m_axis_tuser  = s_axis_tuser;
        m_axis_tlast  = s_axis_tlast;
        m_axis_tvalid = s_axis_tvalid;
        s_axis_tready = m_axis_tready;
      end
      default: ;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      state_reg      <= ST_IDLE;
      head_tdata_reg <= '0;
      head_tkeep_reg <= '0;
      head_tuser_reg <= '0;
      head_tlast_reg <= 1'b0;
      dst_mac_reg    <= '0;
      src_mac_reg    <= '0;
      src_port_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (in_fire) begin
        head_tdata_reg <= s_axis_tdata;
        head_tkeep_reg <= s_axis_tkeep;
        head_tuser_reg <= s_axis_tuser;
        head_tlast_reg <= s_axis_tlast;
        dst_mac_reg    <= s_axis_tdata[47:0];
        src_mac_reg    <= s_axis_tdata[95:48];
        src_port_reg   <= src_port_field;
      end
      if (wait_done) begin
        head_tuser_reg[31:24] <= port_field;
      end
    end
  end

  // Results are only counted when they complete the outstanding lookup.
  always_ff @(posedge axi_aclk or negedge axi_resetn) begin
    if (!axi_resetn) begin
      pkt_cnt_reg  <= '0;
      hit_cnt_reg  <= '0;
      miss_cnt_reg <= '0;
    end else begin
      if (head_fire) pkt_cnt_reg <= pkt_cnt_reg + 32'd1;
      if (wait_done && lut_hit) hit_cnt_reg <= hit_cnt_reg + 32'd1;
      if (wait_done && lut_miss) miss_cnt_reg <= miss_cnt_reg + 32'd1;
    end
  end

  assign dst_mac  = dst_mac_reg;
  assign src_mac  = src_mac_reg;
  assign src_port = src_port_reg;
  assign pkt_cnt  = pkt_cnt_reg;
  assign hit_cnt  = hit_cnt_reg;
  assign miss_cnt = miss_cnt_reg;

endmodule

// File: tb/tb_eth_hdr_lookup_ctrl.sv
// Directed bench for eth_hdr_lookup_ctrl with a behavioural CAM responder and an
// egress monitor; each scenario task checks its own results.
module tb_eth_hdr_lookup_ctrl;
  localparam int DW = 256;
  localparam int UW = 128;
  localparam int KW = DW / 8;
  localparam int NQ = 8;

  logic          clk = 1'b0;
  logic          axi_resetn;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic [UW-1:0] s_axis_tuser;
  logic          s_axis_tvalid;
  logic          s_axis_tlast;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  logic [47:0]   dst_mac;
  logic [47:0]   src_mac;
  logic [NQ-1:0] src_port;
  logic          lookup_req;
  logic [NQ-1:0] dst_ports;
  logic          lookup_done;
  logic          lut_hit;
  logic          lut_miss;
  logic [31:0]   pkt_cnt;
  logic [31:0]   hit_cnt;
  logic [31:0]   miss_cnt;

  int checks = 0;
  int failures = 0;

  // CAM behaviour and egress handshake control
  int       cam_delay = 1;
  logic [7:0] cam_ports = 8'h00;
  logic     cam_hit = 1'b1;
  logic     cam_miss = 1'b0;
  logic     rdy_toggle = 1'b0;
  logic     rdy_level = 1'b1;

  // monitor records
  logic [DW-1:0] egr_data[$];
  logic [UW-1:0] egr_user[$];
  logic [KW-1:0] egr_keep[$];
  logic          egr_last[$];
  int            req_count = 0;
  logic [47:0]   last_dmac = '0;
  logic [47:0]   last_smac = '0;
  logic [NQ-1:0] last_sport = '0;

  // expected beats built from the stimulus
  logic [DW-1:0] exp_data[$];
  logic [UW-1:0] exp_user[$];
  logic [KW-1:0] exp_keep[$];
  logic          exp_last[$];
  int            first_wait = 0;

  eth_hdr_lookup_ctrl #(
    .C_AXIS_DATA_WIDTH (DW),
    .C_AXIS_TUSER_WIDTH(UW),
    .NUM_OUTPUT_QUEUES (NQ)
  ) dut (
    .axi_aclk     (clk),
    .axi_resetn   (axi_resetn),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tuser (s_axis_tuser),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tuser (m_axis_tuser),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready),
    .dst_mac      (dst_mac),
    .src_mac      (src_mac),
    .src_port     (src_port),
    .lookup_req   (lookup_req),
    .dst_ports    (dst_ports),
    .lookup_done  (lookup_done),
    .lut_hit      (lut_hit),
    .lut_miss     (lut_miss),
    .pkt_cnt      (pkt_cnt),
    .hit_cnt      (hit_cnt),
    .miss_cnt     (miss_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready = rdy_toggle ? ~m_axis_tready : rdy_level;
    end
  end

  // CAM: answers cam_delay cycles after seeing the request strobe
  initial begin
    lookup_done = 1'b0;
    lut_hit     = 1'b0;
    lut_miss    = 1'b0;
    dst_ports   = '0;
    forever begin
      @(negedge clk);
      if (axi_resetn && lookup_req) begin
        repeat (cam_delay) @(posedge clk);
        #1;
        dst_ports   = cam_ports;
        lut_hit     = cam_hit;
        lut_miss    = cam_miss;
        lookup_done = 1'b1;
        @(posedge clk);
        #1;
        lookup_done = 1'b0;
        lut_hit     = 1'b0;
        lut_miss    = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (axi_resetn) begin
        if (m_axis_tvalid && m_axis_tready) begin
          egr_data.push_back(m_axis_tdata);
          egr_user.push_back(m_axis_tuser);
          egr_keep.push_back(m_axis_tkeep);
          egr_last.push_back(m_axis_tlast);
        end
        if (lookup_req) begin
          req_count  = req_count + 1;
          last_dmac  = dst_mac;
          last_smac  = src_mac;
          last_sport = src_port;
        end
      end
    end
  end

  // Drives beats 0..stop_after-1 of a len-beat packet; entered and left at posedge+1.
  task automatic send_pkt(input int len, input int stop_after, input logic [47:0] dmac,
                          input logic [47:0] smac, input logic [7:0] sport, input int seed);
    logic [DW-1:0] d;
    logic [UW-1:0] u;
    logic [UW-1:0] eu;
    logic [KW-1:0] k;
    int w;
    for (int i = 0; i < stop_after; i++) begin
      d = {8{32'(seed * 256 + i) ^ 32'h5A5A_0000}};
      u = {4{32'(seed * 256 + i) ^ 32'h0000_C3C3}};
      if (i == 0) begin
        d[47:0]  = dmac;
        d[95:48] = smac;
        u[23:16] = sport;
        u[31:24] = 8'hA5;
      end
      k  = (i == len - 1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
      eu = u;
      if (i == 0) eu[31:24] = cam_ports;
      exp_data.push_back(d);
      exp_user.push_back(eu);
      exp_keep.push_back(k);
      exp_last.push_back(i == len - 1);
      s_axis_tdata  = d;
      s_axis_tuser  = u;
      s_axis_tkeep  = k;
      s_axis_tlast  = (i == len - 1);
      s_axis_tvalid = 1'b1;
      w = 0;
      @(negedge clk);
      while (!s_axis_tready && w < 60) begin
        w++;
        @(negedge clk);
      end
      if (w >= 60) begin
        checks++;
        failures++;
        $display("FAIL send_timeout seed=%0d beat=%0d tready=%b required=1", seed, i, s_axis_tready);
      end
      if (i == 0) first_wait = w;
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic wait_egress(input int n);
    int w;
    w = 0;
    do begin
      @(posedge clk);
      w++;
    end while (egr_data.size() < n && w < 100);
    if (egr_data.size() < n) begin
      checks++;
      failures++;
      $display("FAIL egress_timeout beats=%0d required=%0d", egr_data.size(), n);
    end
    #1;
  endtask

  task automatic test_reset();
    axi_resetn    = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tuser  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    #12;
    checks++;
    if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0 || lookup_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs tready=%b tvalid=%b req=%b required=0/0/0", s_axis_tready, m_axis_tvalid, lookup_req);
    end
    checks++;
    if (pkt_cnt !== 32'd0 || hit_cnt !== 32'd0 || miss_cnt !== 32'd0 || dst_mac !== 48'd0 || src_port !== 8'd0) begin
      failures++;
      $display("FAIL reset_regs pkt=%0d hit=%0d miss=%0d dmac=%h sport=%h required zeros", pkt_cnt, hit_cnt, miss_cnt, dst_mac, src_port);
    end
    @(posedge clk);
    #1;
    axi_resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (s_axis_tready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_tready got=%b required=1", s_axis_tready);
    end
    @(posedge clk);
    #1;
    $display("test_reset done");
  endtask

  task automatic test_single_beat();
    int eb, xb, rb, lat;
    eb = egr_data.size(); xb = exp_data.size(); rb = req_count;
    cam_ports = 8'h54; cam_hit = 1'b1; cam_miss = 1'b0; cam_delay = 1;
    send_pkt(1, 1, 48'h0000_1111_2222, 48'hAABB_CCDD_EEFF, 8'h01, 1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!m_axis_tvalid && lat < 20);
    @(posedge clk);
    #1;
    checks++;
    if (lat !== 3) begin
      failures++;
      $display("FAIL single_latency got=%0d required=3", lat);
    end
    checks++;
    if (req_count - rb !== 1 || last_dmac !== 48'h0000_1111_2222 || last_smac !== 48'hAABB_CCDD_EEFF || last_sport !== 8'h01) begin
      failures++;
      $display("FAIL single_lookup reqs=%0d dmac=%h smac=%h sport=%h required 1/000011112222/aabbccddeeff/01",
               req_count - rb, last_dmac, last_smac, last_sport);
    end
    checks++;
    if (egr_data.size() - eb !== 1 || egr_user[eb][31:24] !== 8'h54 || egr_last[eb] !== 1'b1 ||
        egr_data[eb] !== exp_data[xb] || egr_user[eb] !== exp_user[xb] || egr_keep[eb] !== exp_keep[xb]) begin
      failures++;
      $display("FAIL single_egress beats=%0d port=%h last=%b required 1/54/1", egr_data.size() - eb, egr_user[eb][31:24], egr_last[eb]);
    end
    checks++;
    if (pkt_cnt !== 32'd1 || hit_cnt !== 32'd1 || miss_cnt !== 32'd0) begin
      failures++;
      $display("FAIL single_counts pkt=%0d hit=%0d miss=%0d required 1/1/0", pkt_cnt, hit_cnt, miss_cnt);
    end
    $display("test_single_beat done latency=%0d", lat);
  endtask

  task automatic test_backpressure();
    int eb, xb;
    eb = egr_data.size(); xb = exp_data.size();
    cam_ports = 8'h99; cam_hit = 1'b1; cam_miss = 1'b0;
    rdy_toggle = 1'b1;
    send_pkt(4, 4, 48'h1234_5678_9ABC, 48'h0102_0304_0506, 8'h02, 2);
    wait_egress(eb + 4);
    rdy_toggle = 1'b0;
    rdy_level  = 1'b1;
    checks++;
    if (egr_data.size() - eb !== 4) begin
      failures++;
      $display("FAIL bp_count got=%0d required=4", egr_data.size() - eb);
    end
    for (int i = 0; i < 4 && eb + i < egr_data.size(); i++) begin
      checks++;
      if (egr_data[eb+i] !== exp_data[xb+i] || egr_user[eb+i] !== exp_user[xb+i] ||
          egr_keep[eb+i] !== exp_keep[xb+i] || egr_last[eb+i] !== exp_last[xb+i]) begin
        failures++;
        $display("FAIL bp_beat%0d user=%h last=%b required user=%h last=%b", i, egr_user[eb+i], egr_last[eb+i], exp_user[xb+i], exp_last[xb+i]);
      end
    end
    $display("test_backpressure done beats=%0d", egr_data.size() - eb);
  endtask

  task automatic test_back_to_back();
    int eb, xb, rb;
    logic [7:0] ports_tab [3];
    ports_tab[0] = 8'h11; ports_tab[1] = 8'h22; ports_tab[2] = 8'h44;
    axi_resetn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    axi_resetn = 1'b1;
    @(posedge clk);
    #1;
    eb = egr_data.size(); xb = exp_data.size(); rb = req_count;
    for (int p = 0; p < 3; p++) begin
      cam_ports = ports_tab[p];
      cam_hit   = (p != 1);
      cam_miss  = (p == 1);
      send_pkt(2, 2, 48'h0A0A_0000_0000 + 48'(p), 48'h0B0B_0000_0000 + 48'(p), 8'h04, 10 + p);
      if (p > 0) begin
        checks++;
        if (first_wait !== 0) begin
          failures++;
          $display("FAIL b2b_first_accept pkt=%0d stall=%0d required=0", p, first_wait);
        end
      end
    end
    wait_egress(eb + 6);
    checks++;
    if (egr_data.size() - eb !== 6 || req_count - rb !== 3) begin
      failures++;
      $display("FAIL b2b_totals beats=%0d reqs=%0d required 6/3", egr_data.size() - eb, req_count - rb);
    end
    for (int i = 0; i < 6 && eb + i < egr_data.size(); i++) begin
      checks++;
      if (egr_data[eb+i] !== exp_data[xb+i] || egr_user[eb+i] !== exp_user[xb+i] || egr_last[eb+i] !== exp_last[xb+i]) begin
        failures++;
        $display("FAIL b2b_beat%0d user=%h last=%b required user=%h last=%b", i, egr_user[eb+i], egr_last[eb+i], exp_user[xb+i], exp_last[xb+i]);
      end
    end
    checks++;
    if (pkt_cnt !== 32'd3 || hit_cnt !== 32'd2 || miss_cnt !== 32'd1) begin
      failures++;
      $display("FAIL b2b_counts pkt=%0d hit=%0d miss=%0d required 3/2/1", pkt_cnt, hit_cnt, miss_cnt);
    end
    $display("test_back_to_back done");
  endtask

  task automatic test_slow_cam();
    int eb, rb, lat, bad;
    eb = egr_data.size(); rb = req_count;
    cam_ports = 8'h66; cam_hit = 1'b1; cam_miss = 1'b0; cam_delay = 5;
    send_pkt(1, 1, 48'h0C0C_0C0C_0C0C, 48'h0D0D_0D0D_0D0D, 8'h08, 20);
    lat = 0; bad = 0;
    do begin
      @(negedge clk);
      lat++;
      if (s_axis_tready) bad++;
    end while (!m_axis_tvalid && lat < 30);
    cam_delay = 1;
    wait_egress(eb + 1);
    checks++;
    if (lat !== 7 || bad !== 0) begin
      failures++;
      $display("FAIL slow_wait latency=%0d ready_cycles=%0d required 7/0", lat, bad);
    end
    checks++;
    if (req_count - rb !== 1 || egr_user[eb][31:24] !== 8'h66) begin
      failures++;
      $display("FAIL slow_lookup reqs=%0d port=%h required 1/66", req_count - rb, egr_user[eb][31:24]);
    end
    checks++;
    if (pkt_cnt !== 32'd4 || hit_cnt !== 32'd3 || miss_cnt !== 32'd1) begin
      failures++;
      $display("FAIL slow_counts pkt=%0d hit=%0d miss=%0d required 4/3/1", pkt_cnt, hit_cnt, miss_cnt);
    end
    $display("test_slow_cam done latency=%0d", lat);
  endtask

  task automatic test_no_result();
    int eb;
    eb = egr_data.size();
    cam_ports = 8'h81; cam_hit = 1'b0; cam_miss = 1'b0;
    send_pkt(1, 1, 48'h0E0E_0E0E_0E0E, 48'h0F0F_0F0F_0F0F, 8'h10, 25);
    wait_egress(eb + 1);
    checks++;
    if (egr_user[eb][31:24] !== 8'h81 || pkt_cnt !== 32'd5 || hit_cnt !== 32'd3 || miss_cnt !== 32'd1) begin
      failures++;
      $display("FAIL no_result port=%h pkt=%0d hit=%0d miss=%0d required 81/5/3/1", egr_user[eb][31:24], pkt_cnt, hit_cnt, miss_cnt);
    end
    $display("test_no_result done");
  endtask

  task automatic test_reset_mid_packet();
    int eb, xb, rb;
    cam_ports = 8'h0F; cam_hit = 1'b1; cam_miss = 1'b0;
    send_pkt(6, 3, 48'h1111_1111_1111, 48'h2222_2222_2222, 8'h20, 30);
    #3;
    axi_resetn = 1'b0;
    #1;
    checks++;
    if (s_axis_tready !== 1'b0 || m_axis_tvalid !== 1'b0 || lookup_req !== 1'b0 || m_axis_tdata !== '0) begin
      failures++;
      $display("FAIL midrst_outputs tready=%b tvalid=%b req=%b required 0/0/0 data zero", s_axis_tready, m_axis_tvalid, lookup_req);
    end
    checks++;
    if (pkt_cnt !== 32'd0 || hit_cnt !== 32'd0 || miss_cnt !== 32'd0 ||
        dst_mac !== 48'd0 || src_mac !== 48'd0 || src_port !== 8'd0) begin
      failures++;
      $display("FAIL midrst_regs pkt=%0d hit=%0d miss=%0d dmac=%h smac=%h required zeros", pkt_cnt, hit_cnt, miss_cnt, dst_mac, src_mac);
    end
    repeat (2) @(posedge clk);
    #1;
    axi_resetn = 1'b1;
    @(negedge clk);
    checks++;
    if (s_axis_tready !== 1'b1) begin
      failures++;
      $display("FAIL midrst_release_tready got=%b required=1", s_axis_tready);
    end
    @(posedge clk);
    #1;
    eb = egr_data.size(); xb = exp_data.size(); rb = req_count;
    cam_ports = 8'h3C;
    send_pkt(2, 2, 48'h3333_4444_5555, 48'h6666_7777_8888, 8'h40, 40);
    wait_egress(eb + 2);
    checks++;
    if (req_count - rb !== 1 || last_dmac !== 48'h3333_4444_5555 || last_sport !== 8'h40) begin
      failures++;
      $display("FAIL midrst_lookup reqs=%0d dmac=%h sport=%h required 1/333344445555/40", req_count - rb, last_dmac, last_sport);
    end
    for (int i = 0; i < 2 && eb + i < egr_data.size(); i++) begin
      checks++;
      if (egr_data[eb+i] !== exp_data[xb+i] || egr_user[eb+i] !== exp_user[xb+i] || egr_last[eb+i] !== exp_last[xb+i]) begin
        failures++;
        $display("FAIL midrst_beat%0d user=%h last=%b required user=%h last=%b", i, egr_user[eb+i], egr_last[eb+i], exp_user[xb+i], exp_last[xb+i]);
      end
    end
    checks++;
    if (egr_data.size() - eb !== 2 || egr_user[eb][31:24] !== 8'h3C || pkt_cnt !== 32'd1 || hit_cnt !== 32'd1) begin
      failures++;
      $display("FAIL midrst_fresh beats=%0d port=%h pkt=%0d hit=%0d required 2/3c/1/1", egr_data.size() - eb, egr_user[eb][31:24], pkt_cnt, hit_cnt);
    end
    $display("test_reset_mid_packet done");
  endtask

  task automatic test_counter_wrap();
    int eb;
    @(negedge clk);
    force dut.miss_cnt_reg = 32'hFFFF_FFFF;
    #1;
    release dut.miss_cnt_reg;
    #1;
    checks++;
    if (miss_cnt !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL wrap_preload got=%h required=ffffffff", miss_cnt);
    end
    @(posedge clk);
    #1;
    eb = egr_data.size();
    cam_ports = 8'h02; cam_hit = 1'b0; cam_miss = 1'b1;
    send_pkt(1, 1, 48'h0101_0101_0101, 48'h0202_0202_0202, 8'h80, 50);
    wait_egress(eb + 1);
    checks++;
    if (miss_cnt !== 32'd0 || hit_cnt !== 32'd1 || pkt_cnt !== 32'd2) begin
      failures++;
      $display("FAIL wrap_miss miss=%h hit=%0d pkt=%0d required 0/1/2", miss_cnt, hit_cnt, pkt_cnt);
    end
    $display("test_counter_wrap done miss_cnt=%h", miss_cnt);
  endtask

  initial begin
    test_reset();
    test_single_beat();
    test_backpressure();
    test_back_to_back();
    test_slow_cam();
    test_no_result();
    test_reset_mid_packet();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
